// File: rtl/cpu_branch_pkg.sv
// Shared branch/flag definitions for the CPU pipeline's branch resolution logic.
package cpu_branch_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_B    = 3'b001,
    BR_CBZ  = 3'b010,
    BR_EQ   = 3'b011,
    BR_NE   = 3'b100,
    BR_LT   = 3'b101,
    BR_GE   = 3'b110,
    BR_RSVD = 3'b111
  } br_type_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE,
    ST_SQUASH
  } squash_state_t;

  function automatic logic is_flag_branch(input br_type_t br);
    return (br == BR_EQ) || (br == BR_NE) || (br == BR_LT) || (br == BR_GE);
  endfunction

  function automatic logic is_real_branch(input br_type_t br);
    return (br != BR_NONE) && (br != BR_RSVD);
  endfunction

endpackage

// File: rtl/flag_branch_unit_cond_eval.sv
// Purely combinational branch condition evaluator: flags + branch type + CBZ zero -> taken.
module cond_eval
  import cpu_branch_pkg::*;
(
  input  logic [3:0] flags,
  input  br_type_t   br_type,
  input  logic       cbz_zero,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (br_type)
      BR_B:    taken = 1'b1;
      BR_CBZ:  taken = cbz_zero;
      BR_EQ:   taken = flags[FLAG_Z];
      BR_NE:   taken = !flags[FLAG_Z];
      BR_LT:   taken = flags[FLAG_N] != flags[FLAG_V];
      BR_GE:   taken = flags[FLAG_N] == flags[FLAG_V];
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// Flag register, branch decision register and squash window for the ID stage.
// Optional macro FLAG_FORWARD_EN: forward EX flags to same-cycle branches instead of stalling.
module flag_branch_unit
  import cpu_branch_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int SQUASH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_valid,
  input  logic                  ex_set_flags,
  input  logic [DATA_WIDTH-1:0] ex_result,
  input  logic                  ex_carry,
  input  logic                  ex_overflow,
  input  logic                  id_valid,
  input  logic [2:0]            id_br_type,
  input  logic [DATA_WIDTH-1:0] id_cbz_value,
  input  logic                  stall,
  input  logic                  flush,
  output logic [3:0]            flags_out,
  output logic                  br_valid,
  output logic                  br_taken,
  output logic                  squash_out,
  output logic                  hazard_stall
);

  localparam logic [2:0] SQUASH_LOAD = 3'(SQUASH_CYCLES);

  br_type_t      br_type;
  squash_state_t state, state_next;
  logic [2:0]    count, count_next;
  logic [3:0]    flags_q, ex_flags, eval_flags;
  logic          flag_write, can_decide, hazard, decide, taken;

  assign br_type    = br_type_t'(id_br_type);
  assign flag_write = ex_valid & ex_set_flags;

  always_comb begin
    ex_flags         = '0;
    ex_flags[FLAG_N] = ex_result[DATA_WIDTH-1];
    ex_flags[FLAG_Z] = (ex_result == '0);
    ex_flags[FLAG_C] = ex_carry;
    ex_flags[FLAG_V] = ex_overflow;
  end

  // The instruction behind a registered taken branch is wrong-path, so it never decides.
  assign can_decide = id_valid & is_real_branch(br_type) & (state == ST_IDLE) & !br_taken;
  assign hazard     = can_decide & is_flag_branch(br_type) & flag_write;

`ifdef FLAG_FORWARD_EN
  assign eval_flags   = flag_write ? ex_flags : flags_q;
  assign hazard_stall = 1'b0;
  assign decide       = can_decide;
`else
  assign eval_flags   = flags_q;
  assign hazard_stall = hazard;
  assign decide       = can_decide & !hazard;
`endif

  cond_eval u_cond_eval (
    .flags    (eval_flags),
    .br_type  (br_type),
    .cbz_zero (id_cbz_value == '0),
    .taken    (taken)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= '0;
    end else if (!flush && !stall && flag_write) begin
      flags_q <= ex_flags;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_valid <= 1'b0;
      br_taken <= 1'b0;
    end else if (flush) begin
      br_valid <= 1'b0;
      br_taken <= 1'b0;
    end else if (!stall) begin
      br_valid <= decide;
      br_taken <= decide & taken;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      count <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
      count <= '0;
    end else if (!stall) begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Counter holds the remaining squash cycles including the current one.
  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      ST_IDLE: begin
        if (br_taken) begin
          state_next = ST_SQUASH;
          count_next = SQUASH_LOAD;
        end
      end
      ST_SQUASH: begin
        if (count <= 3'd1) begin
          state_next = ST_IDLE;
          count_next = '0;
        end else begin
          count_next = count - 3'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        count_next = '0;
      end
    endcase
  end

  assign squash_out = (state == ST_SQUASH);
  assign flags_out  = flags_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed self-checking bench for flag_branch_unit (default SQUASH_CYCLES=2, DATA_WIDTH=16).
module tb_flag_branch_unit;
  import cpu_branch_pkg::*;

  logic        clk;
  logic        reset;
  logic        ex_valid;
  logic        ex_set_flags;
  logic [15:0] ex_result;
  logic        ex_carry;
  logic        ex_overflow;
  logic        id_valid;
  logic [2:0]  id_br_type;
  logic [15:0] id_cbz_value;
  logic        stall;
  logic        flush;
  logic [3:0]  flags_out;
  logic        br_valid;
  logic        br_taken;
  logic        squash_out;
  logic        hazard_stall;

  int checks = 0;
  int errors = 0;

  flag_branch_unit #(.DATA_WIDTH(16), .SQUASH_CYCLES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .ex_valid     (ex_valid),
    .ex_set_flags (ex_set_flags),
    .ex_result    (ex_result),
    .ex_carry     (ex_carry),
    .ex_overflow  (ex_overflow),
    .id_valid     (id_valid),
    .id_br_type   (id_br_type),
    .id_cbz_value (id_cbz_value),
    .stall        (stall),
    .flush        (flush),
    .flags_out    (flags_out),
    .br_valid     (br_valid),
    .br_taken     (br_taken),
    .squash_out   (squash_out),
    .hazard_stall (hazard_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic exv, input logic exs, input logic [15:0] res,
                                input logic car, input logic ovf, input logic idv,
                                input logic [2:0] br, input logic [15:0] cbz);
    ex_valid     = exv;
    ex_set_flags = exs;
    ex_result    = res;
    ex_carry     = car;
    ex_overflow  = ovf;
    id_valid     = idv;
    id_br_type   = br;
    id_cbz_value = cbz;
  endtask

  task automatic idle_inputs();
    apply_stimulus(1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, BR_NONE, 16'h0000);
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    idle_inputs();
    #1;
    check_output("reset_flags", flags_out, 4'b0000);
    check_output("reset_valid", {3'b0, br_valid}, 4'd0);
    check_output("reset_squash", {3'b0, squash_out}, 4'd0);
    tick();
    tick();
    reset = 1'b0;

    // SUBS giving zero, then B.EQ on the next cycle
    apply_stimulus(1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, BR_NONE, 16'h0000);
    tick();
    check_output("subs_zero_flags", flags_out, 4'b0100);
    apply_stimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, BR_EQ, 16'h0000);
    #1;
    check_output("beq_no_hazard", {3'b0, hazard_stall}, 4'd0);
    tick();
    check_output("beq_valid", {3'b0, br_valid}, 4'd1);
    check_output("beq_taken", {3'b0, br_taken}, 4'd1);
    check_output("beq_squash_pre", {3'b0, squash_out}, 4'd0);
    idle_inputs();
    tick();
    check_output("beq_valid_cleared", {3'b0, br_valid}, 4'd0);
    check_output("beq_squash_c1", {3'b0, squash_out}, 4'd1);
    tick();
    check_output("beq_squash_c2", {3'b0, squash_out}, 4'd1);
    tick();
    check_output("beq_squash_end", {3'b0, squash_out}, 4'd0);

    // CBZ on a non-zero operand falls through
    apply_stimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, BR_CBZ, 16'h0001);
    tick();
    check_output("cbz_valid", {3'b0, br_valid}, 4'd1);
    check_output("cbz_not_taken", {3'b0, br_taken}, 4'd0);
    idle_inputs();
    tick();
    check_output("cbz_no_squash", {3'b0, squash_out}, 4'd0);
    check_output("cbz_valid_cleared", {3'b0, br_valid}, 4'd0);

    // Reserved code is not a branch
    apply_stimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, BR_RSVD, 16'h0000);
    tick();
    check_output("rsvd_valid", {3'b0, br_valid}, 4'd0);

    // B.LT in ID while SUBS in EX produces N=1, V=0 (old flags say not-less-than)
    apply_stimulus(1'b1, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b1, BR_LT, 16'h0000);
    #1;
`ifdef FLAG_FORWARD_EN
    check_output("blt_fwd_no_hazard", {3'b0, hazard_stall}, 4'd0);
    tick();
    check_output("blt_fwd_flags", flags_out, 4'b1010);
    check_output("blt_fwd_valid", {3'b0, br_valid}, 4'd1);
    check_output("blt_fwd_taken", {3'b0, br_taken}, 4'd1);
`else
    check_output("blt_hazard", {3'b0, hazard_stall}, 4'd1);
    tick();
    check_output("blt_hazard_flags", flags_out, 4'b1010);
    check_output("blt_hazard_no_valid", {3'b0, br_valid}, 4'd0);
    apply_stimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, BR_LT, 16'h0000);
    #1;
    check_output("blt_retry_no_hazard", {3'b0, hazard_stall}, 4'd0);
    tick();
    check_output("blt_retry_valid", {3'b0, br_valid}, 4'd1);
    check_output("blt_retry_taken", {3'b0, br_taken}, 4'd1);
`endif

    // Stall for three cycles inside the squash window
    idle_inputs();
    tick();
    check_output("stall_squash_c1", {3'b0, squash_out}, 4'd1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("stall_squash_hold", {3'b0, squash_out}, 4'd1);
    end
    stall = 1'b0;
    tick();
    check_output("stall_squash_c2", {3'b0, squash_out}, 4'd1);
    tick();
    check_output("stall_squash_end", {3'b0, squash_out}, 4'd0);

    // Flush on the cycle the taken decision is registered
    apply_stimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, BR_B, 16'h0000);
    tick();
    check_output("flush_pre_taken", {3'b0, br_taken}, 4'd1);
    idle_inputs();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_output("flush_valid", {3'b0, br_valid}, 4'd0);
    check_output("flush_taken", {3'b0, br_taken}, 4'd0);
    check_output("flush_squash", {3'b0, squash_out}, 4'd0);
    check_output("flush_flags_kept", flags_out, 4'b1010);
    tick();
    check_output("flush_no_squash_later", {3'b0, squash_out}, 4'd0);

    // Stall holds the registered decision, then reset lands in squash cycle 1
    apply_stimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, BR_B, 16'h0000);
    tick();
    idle_inputs();
    stall = 1'b1;
    tick();
    check_output("stall_hold_valid", {3'b0, br_valid}, 4'd1);
    check_output("stall_hold_taken", {3'b0, br_taken}, 4'd1);
    check_output("stall_hold_no_squash", {3'b0, squash_out}, 4'd0);
    stall = 1'b0;
    tick();
    check_output("pre_reset_squash", {3'b0, squash_out}, 4'd1);
    #2;
    reset = 1'b1;
    #1;
    check_output("async_reset_squash", {3'b0, squash_out}, 4'd0);
    check_output("async_reset_flags", flags_out, 4'b0000);
    check_output("async_reset_taken", {3'b0, br_taken}, 4'd0);
    tick();
    reset = 1'b0;
    tick();
    check_output("post_reset_squash", {3'b0, squash_out}, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flag_branch_unit.md
Name: flag_branch_unit

Overview:
- Consumer side of the ALU zero/condition logic in the pipelined CPU.
- Captures N/Z/C/V from the EX stage into an architectural flag register.
- Resolves conditional branches in ID against those flags (or against a register value for CBZ).
- Registers the taken/not-taken decision and drives a timed squash window for wrong-path instructions.

Parameters:
- DATA_WIDTH, 16, width of ALU result and CBZ operand.
- SQUASH_CYCLES, 2, cycles squash_out stays high after a taken branch (1..7).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ex_valid  in  1  EX stage holds a valid instruction.
- ex_set_flags  in  1  EX instruction writes flags (ADDS/SUBS).
- ex_result  in  DATA_WIDTH  ALU result in EX.
- ex_carry  in  1  ALU carry-out.
- ex_overflow  in  1  ALU signed overflow.
- id_valid  in  1  ID stage holds a valid instruction.
- id_br_type  in  3  branch code (see Behaviour).
- id_cbz_value  in  DATA_WIDTH  register operand tested by CBZ.
- stall  in  1  global pipeline stall; holds all state.
- flush  in  1  external flush (exception); cancels pending decision and squash.
- flags_out  out  4  {N,Z,C,V} architectural flags.
- br_valid  out  1  registered: decision below is meaningful.
- br_taken  out  1  registered branch decision.
- squash_out  out  1  kill IF/ID wrong-path instructions.
- hazard_stall  out  1  combinational request to stall ID one cycle.

Behaviour:
- Reset (async, immediate): flags_out=0, br_valid=0, br_taken=0, squash_out=0, squash counter=0, state=IDLE.
- Flag capture: on a clock edge with ex_valid & ex_set_flags & !stall, the unit loads the following:
  - N = ex_result[DATA_WIDTH-1]
  - Z = (ex_result == 0), full-width compare
  - C = ex_carry
  - V = ex_overflow
- Branch codes:
  - 000 none
  - 001 B (always taken)
  - 010 CBZ (taken if id_cbz_value == 0)
  - 011 B.EQ (Z)
  - 100 B.NE (!Z)
  - 101 B.LT (N != V)
  - 110 B.GE (N == V)
  - 111 reserved, treated as none
- Flag-consuming branches are codes 011..110.
- Decision latency is 1 cycle. The branch is evaluated in the ID cycle. br_valid and br_taken are registered at the next edge and held 1 cycle, then cleared.
- br_valid=1 for any id_valid branch code 001..110 that is not stalled or squashed. Code 000 or 111 gives br_valid=0.
- Flag hazard: a flag-consuming branch in ID while ex_valid & ex_set_flags. Resolution is governed by FLAG_FORWARD_EN.
- Squash state machine (IDLE, SQUASH):
  - A registered br_taken=1 moves IDLE -> SQUASH.
  - The counter loads SQUASH_CYCLES.
  - squash_out=1 while in SQUASH; the counter decrements each unstalled cycle.
  - The unit returns to IDLE when the counter reaches 0.
  - In SQUASH, id_valid is ignored: no decisions and no hazard_stall.
- stall: freezes flags, decision registers, state and counter. br_valid/br_taken hold their value.
- flush: at the next edge, clears br_valid, br_taken, squash_out and the counter, and goes to IDLE. Flags are retained.
- Precedence: reset > flush > stall > normal.
- A flag write and a flag-consuming branch in the same cycle with forwarding use the new flags. The register update and decision occur on the same edge.

Optional Feature:
- Macro: FLAG_FORWARD_EN.
- Defined: a hazard branch evaluates on flags computed combinationally from ex_result/ex_carry/ex_overflow; hazard_stall is tied 0.
- Undefined:
  - A hazard branch asserts hazard_stall=1 that cycle and produces no decision.
  - The decision is made the following cycle from the updated flag register.
  - Net result: one extra cycle of branch latency.

Decomposition:
- Shared package cpu_branch_pkg holds:
  - the br_type_t enum (3-bit codes above)
  - flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
  - the squash FSM state enum
- One natural sub-module: cond_eval. It is purely combinational: flags + br_type + cbz zero -> taken. It is reused by any later branch predictor checker.

Test Plan:
- Reset mid-squash: SQUASH_CYCLES=2, taken B, reset asserted in squash cycle 1 -> all outputs 0 immediately, state IDLE.
- SUBS ex_result=16'h0000 then B.EQ next cycle -> flags_out=4'b0100, br_valid=1, br_taken=1, squash_out high exactly 2 cycles.
- CBZ with id_cbz_value=16'h0001 -> br_valid=1, br_taken=0, squash_out stays 0.
- B.LT with SUBS same cycle producing N=1, V=0:
  - with FLAG_FORWARD_EN: br_taken=1 next cycle, hazard_stall=0.
  - without: hazard_stall=1 one cycle, then br_taken=1 one cycle later.
- stall held 3 cycles during SQUASH -> squash_out stays 1 and the counter does not advance; total squash = 2 unstalled cycles.
- flush on the cycle br_taken=1 registers -> squash never starts, br_valid=0 next cycle, flags unchanged.
